// File: rtl/window_mac5_acc_pkg.sv
// window_mac5_acc_pkg: shared FSM states, fixed-point defaults and saturating round helper
package window_mac5_acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;
  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_FRAC_BITS = 8;
  // round half up by frac bits, then clamp to a signed ww-bit range
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] a, input int frac, input int ww);
    logic signed [63:0] r, hi, lo;
    r = (a + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (ww - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/window_mac5_acc_mac5_pipe.sv
// mac5_pipe: five signed multipliers and adder tree with registered product and sum stages
module mac5_pipe
  import window_mac5_acc_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [WORD_WIDTH-1:0]  data [5],
  input  logic signed [WORD_WIDTH-1:0]  weight [5],
  output logic                          sum_valid,
  output logic signed [2*WORD_WIDTH+2:0] sum
);
  localparam int PW = 2 * WORD_WIDTH;
  localparam int SW = PW + 3;
  logic signed [PW-1:0] prod [5];
  logic prod_valid;
  always_ff @(posedge clk)
    if (rst) begin
      prod_valid <= 1'b0;
      sum_valid <= 1'b0;
      sum <= '0;
      for (int i = 0; i < 5; i++) prod[i] <= '0;
    end else begin
      prod_valid <= in_valid;
      sum_valid <= prod_valid;
      if (in_valid) for (int i = 0; i < 5; i++) prod[i] <= PW'(data[i]) * PW'(weight[i]);
      if (prod_valid) sum <= SW'(prod[0]) + SW'(prod[1]) + SW'(prod[2]) + SW'(prod[3]) + SW'(prod[4]);
    end
endmodule

// File: rtl/window_mac5_acc.sv
// window_mac5_acc: 5-tap weighted window MAC accumulated over acc_len windows, rounded and saturated
module window_mac5_acc
  import window_mac5_acc_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int CNT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 2 * WORD_WIDTH + CNT_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_load,
  input  logic [2:0]            w_idx,
  input  logic [WORD_WIDTH-1:0] w_data,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  acc_len,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] data_in_0,
  input  logic [WORD_WIDTH-1:0] data_in_1,
  input  logic [WORD_WIDTH-1:0] data_in_2,
  input  logic [WORD_WIDTH-1:0] data_in_3,
  input  logic [WORD_WIDTH-1:0] data_in_4,
  output logic                  busy,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data
);
  state_t state, state_nx;
  logic signed [WORD_WIDTH-1:0] weight [5];
  logic signed [WORD_WIDTH-1:0] window [5];
  logic [CNT_WIDTH-1:0] len, cnt;
  logic drain_cnt;
  logic sum_valid;
  logic signed [2*WORD_WIDTH+2:0] sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic accept, last, go;
  assign window = '{data_in_0, data_in_1, data_in_2, data_in_3, data_in_4};
  assign go = state == IDLE && start && acc_len != '0;
  assign accept = state == ACCUM && in_valid;
  assign last = accept && cnt + CNT_WIDTH'(1) == len;
  assign busy = state != IDLE;
  mac5_pipe #(.WORD_WIDTH(WORD_WIDTH)) u_pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(accept),
    .data(window),
    .weight(weight),
    .sum_valid(sum_valid),
    .sum(sum)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = go ? ACCUM : IDLE;
      ACCUM: state_nx = last ? DRAIN : ACCUM;
      DRAIN: state_nx = drain_cnt ? OUT : DRAIN;
      OUT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      drain_cnt <= 1'b0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      for (int i = 0; i < 5; i++) weight[i] <= '0;
    end else begin
      state <= state_nx;
      out_valid <= state == OUT;
      if (state == IDLE && w_load && w_idx < 3'd5) weight[w_idx] <= w_data;
      if (go) begin
        len <= acc_len;
        cnt <= '0;
        acc <= '0;
      end else if (sum_valid) acc <= acc + ACC_WIDTH'(sum);
      if (accept) cnt <= cnt + CNT_WIDTH'(1);
      drain_cnt <= state == DRAIN && !drain_cnt;
      if (state == OUT) out_data <= WORD_WIDTH'(sat_round(64'(acc), FRAC_BITS, WORD_WIDTH));
    end
endmodule

// File: tb/tb_window_mac5_acc.sv
// tb_window_mac5_acc: directed checks of the window MAC accumulator
module tb_window_mac5_acc;
  logic clk = 0, rst = 1, w_load = 0, start = 0, in_valid = 0;
  logic [2:0] w_idx = 0;
  logic [15:0] w_data = 0, d0 = 0, d1 = 0, d2 = 0, d3 = 0, d4 = 0;
  logic [7:0] acc_len = 0;
  logic busy, out_valid;
  logic [15:0] out_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  window_mac5_acc dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
    .start(start), .acc_len(acc_len), .in_valid(in_valid),
    .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .data_in_3(d3), .data_in_4(d4),
    .busy(busy), .out_valid(out_valid), .out_data(out_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_w(input logic [2:0] idx, input logic [15:0] val);
    w_load = 1; w_idx = idx; w_data = val;
    tick();
    w_load = 0;
  endtask
  task automatic load_all(input logic [15:0] val);
    for (int i = 0; i < 5; i++) load_w(3'(i), val);
  endtask
  task automatic set_win(input logic [15:0] a, b, c, d, e);
    d0 = a; d1 = b; d2 = c; d3 = d; d4 = e;
  endtask
  task automatic begin_run(input logic [7:0] n);
    start = 1; acc_len = n;
    tick();
    start = 0;
    chk("busy_after_start", 32'(busy), 1);
  endtask
  task automatic win();
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      chk("gap_no_valid", 32'(out_valid), 0);
      chk("gap_busy", 32'(busy), 1);
      tick();
    end
  endtask
  // entered in cycle T+1 after the last window; result must appear in T+4 only
  task automatic expect_out(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_early"}, 32'(out_valid), 0);
      chk({tag, "_busy"}, 32'(busy), 1);
      tick();
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_idle"}, 32'(busy), 0);
    tick();
    chk({tag, "_pulse"}, 32'(out_valid), 0);
    chk({tag, "_hold"}, 32'(out_data), 32'(exp));
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    load_all(16'h0100);
    set_win(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500);
    begin_run(1); win();
    expect_out("single", 16'h0F00);
    begin_run(3); win(); gap(2); win(); gap(5); win();
    expect_out("gaps", 16'h2D00);
    begin_run(1);
    start = 1; acc_len = 5; tick(); start = 0;
    win();
    expect_out("start_in_accum", 16'h0F00);
    begin_run(1);
    load_w(0, 16'h7FFF);
    win();
    expect_out("wload_in_accum", 16'h0F00);
    start = 1; acc_len = 0; tick(); start = 0;
    chk("len0_busy", 32'(busy), 0);
    tick();
    chk("len0_busy2", 32'(busy), 0);
    load_w(5, 16'h7FFF);
    begin_run(1); win();
    expect_out("widx5", 16'h0F00);
    load_all(16'h0000);
    load_w(0, 16'h0080);
    set_win(16'h0001, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    begin_run(1); win();
    expect_out("round_up", 16'h0001);
    d0 = 16'hFFFF;
    begin_run(1); win();
    expect_out("round_neg", 16'h0000);
    load_all(16'h7FFF);
    set_win(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    begin_run(4); win(); win(); win(); win();
    expect_out("sat_pos", 16'h7FFF);
    set_win(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    begin_run(1); win();
    expect_out("sat_neg", 16'h8000);
    begin_run(2); win();
    rst = 1; tick(); rst = 0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_out", 32'(out_valid), 0);
      tick();
    end
    begin_run(1); win();
    expect_out("weights_cleared", 16'h0000);
    load_all(16'h0100);
    set_win(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500);
    begin_run(1); win();
    expect_out("after_rst", 16'h0F00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
